// File: rtl/conv_mac_seq.sv
// Sequential convolution MAC: fetches K products per output pixel from a product
// buffer, accumulates them modulo 2^(2W+1), and emits results in raster order.

package yolo_params_pkg;
    parameter int IP_DATA_WIDTH = 8;
    parameter int OFMAP_SIZE    = 2;
    parameter int FILTER_SIZE   = 3;
endpackage

module conv_mac_seq #(
    parameter int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
    parameter int OFMAP_SIZE    = yolo_params_pkg::OFMAP_SIZE,
    parameter int FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE,
    localparam int W  = IP_DATA_WIDTH,
    localparam int N  = OFMAP_SIZE,
    localparam int P  = N * N,
    localparam int K  = FILTER_SIZE * FILTER_SIZE,
    localparam int PW = (P > 1) ? $clog2(P) : 1,
    localparam int TW = (K > 1) ? $clog2(K) : 1,
    localparam int NW = (N > 1) ? $clog2(N) : 1,
    localparam int AW = 2 * W + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [PW-1:0]   rd_pix,
    output logic [TW-1:0]   rd_tap,
    input  logic [2*W-1:0]  rd_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [NW-1:0]   res_row,
    output logic [NW-1:0]   res_col,
    output logic [AW-1:0]   res_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [TW-1:0] TAP_LAST = TW'(K - 1);
    localparam logic [NW-1:0] IDX_LAST = NW'(N - 1);

    state_t         state_r;
    logic [AW-1:0]  acc_r;
    logic           rd_en_d_r;
    logic [AW-1:0]  sum_s;
    logic           last_pix_s;

    // Running sum including the product returned for last cycle's read.
    always_comb begin
        sum_s      = acc_r + AW'(rd_data);
        last_pix_s = (res_row == IDX_LAST) && (res_col == IDX_LAST);
    end

    // Control FSM, read addressing, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_en_d_r <= 1'b0;
            rd_pix    <= '0;
            rd_tap    <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
            res_col   <= '0;
            res_data  <= '0;
            acc_r     <= '0;
        end else begin
            rd_en_d_r <= rd_en;
            done      <= 1'b0;
            // Products arrive one cycle after their read, so this also covers DRAIN.
            if (rd_en_d_r) begin
                acc_r <= sum_s;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        res_row <= '0;
                        res_col <= '0;
                        rd_pix  <= '0;
                        rd_tap  <= '0;
                        acc_r   <= '0;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_tap == TAP_LAST) begin
                        rd_en   <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        rd_tap <= rd_tap + TW'(1);
                    end
                end
                DRAIN: begin
                    res_data  <= sum_s;
                    res_valid <= 1'b1;
                    state_r   <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        acc_r     <= '0;
                        rd_tap    <= '0;
                        if (last_pix_s) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            if (res_col == IDX_LAST) begin
                                res_col <= '0;
                                res_row <= res_row + NW'(1);
                            end else begin
                                res_col <= res_col + NW'(1);
                            end
                            rd_pix  <= rd_pix + PW'(1);
                            rd_en   <= 1'b1;
                            state_r <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                    res_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq with W=8, F=3 (K=9), N=2 (P=4) and a
// product-buffer responder that returns data one cycle after each read.

module tb_conv_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_pix;
    logic [3:0]  rd_tap;
    logic [15:0] rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [0:0]  res_row;
    logic [0:0]  res_col;
    logic [16:0] res_data;

    int checks = 0;
    int errors = 0;
    int data_mode = 0;

    typedef struct {
        int               mode;
        int               stall;
        int               retrig;
        logic [3:0][16:0] exp;
    } vec_t;

    vec_t vecs[5];

    conv_mac_seq #(.IP_DATA_WIDTH(8), .OFMAP_SIZE(2), .FILTER_SIZE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_pix(rd_pix), .rd_tap(rd_tap), .rd_data(rd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_col(res_col), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Product buffer: word for (pix, tap) is valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            case (data_mode)
                0:       rd_data <= 16'd1;
                1:       rd_data <= 16'd65025;
                default: rd_data <= 16'({rd_pix, 4'b0000}) + 16'(rd_tap);
            endcase
        end else begin
            rd_data <= 16'hDEAD;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_map(input vec_t v);
        int nres = 0;
        int ndone = 0;
        int done_cyc = -1;
        int stall_left = v.stall;
        logic [16:0] held = '0;
        data_mode = v.mode;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = (v.retrig != 0) && (n == 15);
            res_ready = 1'b1;
            if (nres == 0 && stall_left > 0 && (res_valid || stall_left < v.stall)) begin
                if (stall_left == v.stall) held = res_data;
                chk("stall_valid", res_valid, 1);
                chk("stall_data", res_data, held);
                chk("stall_rd_en", rd_en, 0);
                res_ready = 1'b0;
                stall_left--;
            end
            if (res_valid && res_ready) begin
                chk("res_data", res_data, v.exp[nres]);
                chk("res_row", res_row, nres / 2);
                chk("res_col", res_col, nres % 2);
                chk("res_cycle", n, 11 * (nres + 1) + v.stall);
                nres++;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) done_cyc = n;
            end
            if (done_cyc > 0 && n >= done_cyc + 3) break;
        end
        chk("result_count", nres, 4);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_cyc, 45 + v.stall);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int activity;
        vecs[0] = '{mode: 0, stall: 0, retrig: 0, exp: {17'd9, 17'd9, 17'd9, 17'd9}};
        vecs[1] = '{mode: 1, stall: 0, retrig: 0, exp: {17'd60937, 17'd60937, 17'd60937, 17'd60937}};
        vecs[2] = '{mode: 2, stall: 0, retrig: 0, exp: {17'd468, 17'd324, 17'd180, 17'd36}};
        vecs[3] = '{mode: 0, stall: 5, retrig: 0, exp: {17'd9, 17'd9, 17'd9, 17'd9}};
        vecs[4] = '{mode: 2, stall: 0, retrig: 1, exp: {17'd468, 17'd324, 17'd180, 17'd36}};

        rst_n = 1'b0;
        start = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, rd_en, rd_pix, rd_tap, res_valid, res_row, res_col, res_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_map(vecs[i]);

        // Reset in the middle of the second pixel's fetch.
        data_mode = 0;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_reset_rd_en", rd_en, 1);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_rd_en", rd_en, 0);
        chk("async_pix", rd_pix, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy || rd_en || res_valid || done) activity++;
        end
        chk("post_reset_quiet", activity, 0);
        run_map(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_mac_seq.md
CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

Interface
REQ-001 SHALL have parameter IP_DATA_WIDTH, default yolo_params_pkg::IP_DATA_WIDTH, input operand width W; product width 2W.
REQ-002 SHALL have parameter OFMAP_SIZE, default yolo_params_pkg::OFMAP_SIZE, output feature map side N; P = N*N pixels.
REQ-003 SHALL have parameter FILTER_SIZE, default yolo_params_pkg::FILTER_SIZE, filter side F; K = F*F taps per pixel.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to process one full feature map; sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last result is accepted.
REQ-009 SHALL have port rd_en  output  1  product-buffer read strobe.
REQ-010 SHALL have port rd_pix  output  clog2(P)  pixel (row) index of the read, equal to row*N+col.
REQ-011 SHALL have port rd_tap  output  clog2(K)  tap (column) index of the read.
REQ-012 SHALL have port rd_data  input  2W  product word; valid exactly one cycle after rd_en.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  consumer accepts the result when res_valid is high.
REQ-015 SHALL have port res_row  output  clog2(N)  result row index.
REQ-016 SHALL have port res_col  output  clog2(N)  result column index.
REQ-017 SHALL have port res_data  output  2W+1  accumulated sum of the K products for the pixel.

Function
REQ-018 SHALL implement the states IDLE, FETCH, DRAIN, OUT and DONE.
REQ-019 In IDLE with start=1, the block SHALL clear row, col, tap and acc, then enter FETCH at the next edge.
REQ-020 In FETCH, the block SHALL drive rd_en=1 and rd_tap=tap, with tap incrementing 0..K-1 over one tap per cycle; after tap K-1 it SHALL enter DRAIN.
REQ-021 On every cycle where rd_en was high in the previous cycle, the block SHALL perform acc <= acc + rd_data, including the DRAIN cycle; acc SHALL be cleared on entry to FETCH for each pixel.
REQ-022 Accumulation SHALL be unsigned, modulo 2^(2W+1) (wrap, no saturation).
REQ-023 DRAIN SHALL last one cycle, with rd_en=0, followed by OUT.
REQ-024 In OUT, res_valid SHALL be 1, and res_data, res_row and res_col SHALL be held stable until res_valid and res_ready are both high.
REQ-025 On acceptance, the block SHALL advance col; at col=N-1 it SHALL wrap col to 0 and increment row; it SHALL re-enter FETCH, or enter DONE if row=N-1 and col=N-1 (raster order).
REQ-026 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-027 start SHALL be ignored in every state other than IDLE; it SHALL never restart or corrupt an in-progress map.
REQ-028 With res_ready held high, per-pixel latency SHALL be K+2 cycles; with start sampled at edge 0, the first OUT cycle is K+2 and done is high in cycle P*(K+2)+1.
REQ-029 res_ready SHALL be ignored outside OUT; the block SHALL assert rd_en only in FETCH.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state IDLE and drive busy=0, done=0, rd_en=0, rd_pix=0, rd_tap=0, res_valid=0, res_row=0, res_col=0, res_data=0, with acc=0.
REQ-031 Reset asserted mid-operation SHALL abandon the map with no further reads or results; after release, the block SHALL wait in IDLE for a new start.

Verification (bench: W=8, F=3 so K=9, N=2 so P=4)
REQ-032 All products=1, res_ready=1, start pulse at edge 0 -> four results of 9 at (0,0),(0,1),(1,0),(1,1) in cycles 11,22,33,44; done pulse in cycle 45.
REQ-033 Products=65025 (255*255) for every tap -> each res_data=60937 (585225 mod 131072), confirming wrap behaviour.
REQ-034 res_ready=0 for 5 cycles during the first OUT -> res_valid and res_data stay stable, rd_en stays 0, and the total run is extended by exactly 5 cycles.
REQ-035 start pulsed again in cycle 15 while busy -> ignored; exactly four results are produced and exactly one done pulse occurs.
REQ-036 rst_n asserted low in cycle 13 -> busy and rd_en fall without waiting for a clock edge; after release with no start, there is no activity; a new start then yields REQ-032 timing relative to that start.
REQ-037 Products equal to rd_pix*16+rd_tap -> sums 36, 180, 324 and 468, checking rd_pix and rd_tap addressing.
